// File: rtl/store_buffer.sv
// store_buffer
// ------------
// Sits between the store-data extender and the byte-lane addressed data
// memory. Each incoming store is checked for natural alignment. An aligned
// store is shifted into its byte lanes, given a 4-bit byte-enable and queued
// in a small in-order FIFO that drains to memory over a valid/ready handshake.
// A misaligned store is dropped, and misaligned pulses for one cycle.
//
// Parameters:
//   DEPTH       number of FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   st_valid    store request valid
//   st_ready    buffer can accept a request (not full, low during reset)
//   st_addr     byte address of the store
//   st_data     store data, low-aligned and zero-extended
//   st_size     00 byte, 01 half, 1x word
//   mem_valid   head entry valid toward memory
//   mem_ready   memory accepts the head entry this cycle
//   mem_addr    word address of the head entry (zero when empty)
//   mem_wdata   lane-shifted data of the head entry (zero when empty)
//   mem_be      byte enables of the head entry (zero when empty)
//   misaligned  one-cycle pulse after a misaligned request was accepted
//   count       number of occupied entries
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     misaligned,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  // Entry storage. It is not reset: count and the pointers decide what is
  // live, so stale contents are never presented.
  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  be_mem   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic        full;
  logic        empty;
  logic        accept;
  logic        is_misaligned;
  logic        enq;
  logic        deq;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // st_ready only looks at registered state and reset. A slot freed by a
  // dequeue becomes usable on the next cycle, which keeps mem_ready off this path.
  assign st_ready  = !reset && !full;
  assign mem_valid = !empty;

  assign accept = st_valid && st_ready;
  assign enq    = accept && !is_misaligned;
  assign deq    = mem_valid && mem_ready;

  // Natural-alignment check on the request's size code.
  always_comb begin
    is_misaligned = 1'b0;
    case (st_size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = st_addr[0];
      default: is_misaligned = |st_addr[1:0];
    endcase
  end

  // Move the low-aligned data into its byte lanes and build the enables.
  // The data arrives zero-extended, so lanes that are not enabled stay 0.
  always_comb begin
    lane_data = '0;
    lane_be   = '0;
    case (st_size)
      2'b00: begin
        lane_data = {24'b0, st_data[7:0]} << {st_addr[1:0], 3'b000};
        lane_be   = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        lane_data = {16'b0, st_data[15:0]} << {st_addr[1], 4'b0000};
        lane_be   = 4'b0011 << {st_addr[1], 1'b0};
      end
      default: begin
        lane_data = st_data;
        lane_be   = 4'b1111;
      end
    endcase
  end

  // Write the formed entry into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr] <= st_addr[31:2];
      data_mem[wr_ptr] <= lane_data;
      be_mem[wr_ptr]   <= lane_be;
    end
  end

  // Pointers, occupancy and the misaligned pulse. Reset has priority, so a
  // mem_ready in the reset cycle does not count as a dequeue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= accept && is_misaligned;
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The head entry goes to memory. Its fields are forced to zero while the
  // buffer is empty.
  assign mem_addr  = empty ? 32'b0 : {addr_mem[rd_ptr], 2'b00};
  assign mem_wdata = empty ? 32'b0 : data_mem[rd_ptr];
  assign mem_be    = empty ? 4'b0  : be_mem[rd_ptr];

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
// ---------------
// Testbench for store_buffer. It keeps a queue-based reference model of the
// buffer contents. Every entry is formed from the store's byte offset and
// byte count, and alignment is checked as addr % size == 0. Directed
// scenarios are followed by a randomized run. All outputs are checked each
// cycle, #1 after the rising edge.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misaligned;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t modelQ[$];
  logic   modelMis = 1'b0;
  int     checks = 0;
  int     errors = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .misaligned (misaligned),
    .count      (count)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Number of bytes a size code stores.
  function automatic int sizeBytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Build the expected memory entry byte by byte. Data byte k lands in lane
  // (offset + k), and every other lane stays zero and disabled.
  function automatic entry_t formEntry(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] sz);
    entry_t e;
    int n;
    int off;
    n   = sizeBytes(sz);
    off = int'(a % 4);
    e.addr  = a & 32'hFFFF_FFFC;
    e.wdata = '0;
    e.be    = '0;
    for (int k = 0; k < n; k++) begin
      e.be[off + k]            = 1'b1;
      e.wdata[8*(off + k) +: 8] = d[8*k +: 8];
    end
    return e;
  endfunction

  // One comparison. A mismatch is counted and reported.
  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all registered-state outputs against the model.
  task automatic checkOutput();
    entry_t head;
    head = '0;
    if (modelQ.size() != 0) head = modelQ[0];
    checkOne("count",      32'(count),     32'(modelQ.size()));
    checkOne("mem_valid",  32'(mem_valid), 32'(modelQ.size() != 0));
    checkOne("mem_addr",   mem_addr,       head.addr);
    checkOne("mem_wdata",  mem_wdata,      head.wdata);
    checkOne("mem_be",     32'(mem_be),    32'(head.be));
    checkOne("misaligned", 32'(misaligned), 32'(modelMis));
  endtask

  // Drive one cycle of inputs and check st_ready before the edge. Then step
  // the model across the edge and check the outputs.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, input logic mr, input logic rst);
    logic rdy;
    logic acc;
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_size   = sz;
    mem_ready = mr;
    reset     = rst;
    #1;
    rdy = !rst && (modelQ.size() < DEPTH);
    checkOne("st_ready", 32'(st_ready), 32'(rdy));
    @(posedge clk);
    if (rst) begin
      modelQ.delete();
      modelMis = 1'b0;
    end else begin
      acc = v && rdy;
      if (mr && modelQ.size() != 0) void'(modelQ.pop_front());
      modelMis = 1'b0;
      if (acc) begin
        if (a % sizeBytes(sz) == 0) modelQ.push_back(formEntry(a, d, sz));
        else modelMis = 1'b1;
      end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] rdata;
    logic [31:0] rmask;
    int          readyBias;

    $display("[TB] store_buffer test start");
    st_valid = 0; st_addr = 0; st_data = 0; st_size = 0; mem_ready = 0; reset = 1;
    @(posedge clk);
    #1;

    // Reset, then one idle cycle.
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Byte store to the top lane, then drain it.
    applyStimulus(1, 32'h0000_0103, 32'h0000_00AB, 2'b00, 0, 0);
    checkOne("tp1_addr",  mem_addr,       32'h0000_0100);
    checkOne("tp1_wdata", mem_wdata,      32'hAB00_0000);
    checkOne("tp1_be",    32'(mem_be),    32'h8);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOne("tp1_count", 32'(count), 32'd0);

    // Half store to the upper half.
    applyStimulus(1, 32'h0000_0202, 32'h0000_1234, 2'b01, 0, 0);
    checkOne("tp2_wdata", mem_wdata,   32'h1234_0000);
    checkOne("tp2_be",    32'(mem_be), 32'hC);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Word store, then a misaligned word store, with memory stalled.
    applyStimulus(1, 32'h0000_0300, 32'hDEAD_BEEF, 2'b10, 0, 0);
    checkOne("tp3_be", 32'(mem_be), 32'hF);
    applyStimulus(1, 32'h0000_0101, 32'h1111_2222, 2'b10, 0, 0);
    checkOne("tp3_mis",   32'(misaligned), 32'd1);
    checkOne("tp3_count", 32'(count),      32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOne("tp3_mis_gone", 32'(misaligned), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOne("tp3_single_write", 32'(count), 32'd0);

    // Fill with four bytes while stalled. A fifth request is held off, even
    // on a cycle where a dequeue also happens.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 32'h10 + 32'(i), 32'(i + 1), 2'b00, 0, 0);
    checkOne("tp4_full_count", 32'(count),    32'd4);
    checkOne("tp4_full_ready", 32'(st_ready), 32'd0);
    applyStimulus(1, 32'h14, 32'h5, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOne("tp4_be",    32'(mem_be), 32'(1) << i);
      checkOne("tp4_wdata", mem_wdata,   32'(i + 1) << (8 * i));
      applyStimulus(0, 0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 32'h20 + 32'(i), 32'(i + 9), 2'b00, 0, 0);
    applyStimulus(1, 32'h24, 32'h5, 2'b00, 1, 0);
    checkOne("tp4_full_deq_count", 32'(count), 32'd3);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Enqueue and dequeue in the same cycle at count 2, then reset at count 3.
    applyStimulus(1, 32'h40, 32'h0000_00A1, 2'b00, 0, 0);
    applyStimulus(1, 32'h42, 32'h0000_B2B2, 2'b01, 0, 0);
    applyStimulus(1, 32'h44, 32'hC3C3_C3C3, 2'b10, 1, 0);
    checkOne("tp5_count", 32'(count), 32'd2);
    checkOne("tp5_order", mem_wdata,  32'hB2B2_0000);
    applyStimulus(1, 32'h49, 32'h0000_00D4, 2'b00, 0, 0);
    checkOne("tp5_count3", 32'(count), 32'd3);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOne("tp5_rst_count", 32'(count),     32'd0);
    checkOne("tp5_rst_valid", 32'(mem_valid), 32'd0);
    checkOne("tp5_rst_wdata", mem_wdata,      32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic. The mem_ready bias changes between phases so the
    // buffer spends time both full and empty, with the occasional reset.
    for (int i = 0; i < 600; i++) begin
      readyBias = (i / 100) % 3;
      rsz   = 2'($urandom_range(0, 3));
      rmask = (rsz == 2'b00) ? 32'h0000_00FF :
              (rsz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      rdata = $urandom & rmask;
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom,
                    rdata,
                    rsz,
                    $urandom_range(0, 3) < readyBias + 1,
                    $urandom_range(0, 79) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
